clarvi_byte_sequencer: RTL and testbench
========================================

Name: clarvi_byte_sequencer

Overview:
- Upstream and downstream companion of the byte-serial ALU.
- Accepts one 64-bit operation and slices rs1/rs2 into eight byte parts. It drives `instr_part` and the operand bytes to the ALU in the order that operation class requires.
- Collects each returned ALU result byte into a 64-bit result register and hands the completed value to writeback over a valid/ready handshake.
- Honours the pipeline `stall` exactly as the ALU does, so the ALU's carry/compare/shift state stays aligned with the part sequence.

Parameters:
- CLEAR_ON_ISSUE, 1, when 1 the result register is zeroed on issue acceptance; when 0 it holds stale bytes until overwritten.

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- stall  in  1  pipeline stall; freezes sequencing and capture
- issue_valid  in  1  operation offered
- issue_ready  out  1  sequencer can accept an operation
- issue_order  in  2  part order: 00 ASC (0..7), 01 DESC (7..0), 10 SHR32 (3,2,1,0,7,6,5,4), 11 reserved (treated as ASC)
- issue_rs1  in  64  operand 1
- issue_rs2  in  64  operand 2
- part_valid  out  1  a part is being presented to the ALU this cycle
- instr_part  out  3  current byte index
- part_first  out  1  first part of the sequence
- part_last  out  1  eighth part of the sequence
- rs1_byte  out  8  issue_rs1[8*instr_part +: 8]
- rs2_byte  out  8  issue_rs2[8*instr_part +: 8]
- alu_result  in  8  ALU result byte for the current part (combinational from the ALU)
- result  out  64  assembled result
- result_valid  out  1  result complete
- result_ready  in  1  writeback consumes the result

Behaviour:
- States: IDLE, RUN, DONE. Reset (reset=0, asynchronous) forces IDLE.
- Reset values:
  - step counter = 0.
  - result = 0, part_valid = 0, result_valid = 0.
  - instr_part = 0, part_first = 0, part_last = 0.
  - Latched operands and order = 0.
  - issue_ready = 1, since it is decoded from IDLE.
- IDLE:
  - issue_ready = 1.
  - On issue_valid, latch rs1, rs2 and order, set step = 0, and clear result if CLEAR_ON_ISSUE; next state RUN.
  - `stall` does not block acceptance.
- RUN:
  - part_valid = 1 and instr_part = order_table[order][step].
  - part_first = (step == 0); part_last = (step == 7).
  - Operand bytes are combinational from the latched operands and instr_part.
  - On each cycle with stall = 0: result[8*instr_part +: 8] <= alu_result and step increments. At step == 7 the next state is DONE.
  - With stall = 1: step, result and all outputs hold; nothing is captured.
- DONE:
  - result_valid = 1, part_valid = 0, issue_ready = 0.
  - On result_ready, next state is IDLE and result holds its value.
  - result_valid deasserts the cycle after the handshake.
- Latency without stalls:
  - Issue accepted at edge T; parts appear in cycles T+1..T+8.
  - result_valid is asserted in cycle T+9.
  - Each stalled cycle adds exactly one cycle.
- Sign extension of 32-bit operations in parts 4..7 is the ALU's responsibility; the sequencer captures bytes verbatim.
- Reset asserted mid-RUN or mid-DONE abandons the operation immediately, clears result, and returns to IDLE. There is no partial result_valid.
- issue_valid while not in IDLE is ignored; the driver must hold the operation until the issue_valid && issue_ready handshake.

Optional Feature:
- CLARVI_SEQ_BYPASS_EN
  - Defined: in DONE, issue_ready = result_ready. A simultaneous result handshake and issue handshake goes DONE -> RUN directly, latching the new operation. This gives back-to-back operations with no IDLE bubble: one result every 9 cycles.
  - Undefined: DONE always passes through IDLE, so one result every 10 cycles.

Test Plan:
- Test 1, ASC loopback.
  - Stimulus: bench ties alu_result = rs1_byte; issue rs1 = 0x0123456789ABCDEF, order 00, no stall.
  - Required response: instr_part = 0,1,...,7 in cycles T+1..T+8; part_first only at T+1; part_last only at T+8; result_valid at T+9; result = 0x0123456789ABCDEF.
- Test 2, DESC and SHR32 ordering.
  - Stimulus: same loopback with orders 01 and 10.
  - Required response: instr_part sequences are 7..0 and 3,2,1,0,7,6,5,4 respectively; result = 0x0123456789ABCDEF for both.
- Test 3, stall.
  - Stimulus: order 00; hold stall = 1 for 3 cycles while step == 2; bench drives alu_result = 0xEE during the stall.
  - Required response: instr_part holds at 2 throughout the stall; byte 2 of result is the value presented in the first unstalled cycle, not 0xEE; result_valid arrives at T+12.
- Test 4, backpressure.
  - Stimulus: hold result_ready = 0 for 5 cycles after completion; pulse issue_valid during that window.
  - Required response: result_valid stays 1 and result holds; issue_ready = 0; the new operation is not accepted.
- Test 5, reset mid-operation.
  - Stimulus: assert reset = 0 asynchronously at step 4.
  - Required response: outputs reach their reset values before the next clock edge; result = 0; after release, issue_ready = 1 and a fresh operation completes correctly.
- Test 6, with CLARVI_SEQ_BYPASS_EN defined.
  - Stimulus: issue_valid and result_ready both high in DONE.
  - Required response: the next part_first occurs in the cycle after the handshake; two operations complete 9 cycles apart.

Source files
------------

// File: rtl/clarvi_byte_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clarvi_byte_sequencer                                                      |
// | Slices a 64-bit operation into eight byte parts for the byte-serial ALU,   |
// | assembles the returned bytes and hands the result to writeback.            |
// | Optional: CLARVI_SEQ_BYPASS_EN (DONE -> RUN with no IDLE bubble).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clarvi_byte_sequencer #(
  parameter int unsigned CLEAR_ON_ISSUE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_order,
  input  logic [63:0] issue_rs1,
  input  logic [63:0] issue_rs2,
  output logic        part_valid,
  output logic [2:0]  instr_part,
  output logic        part_first,
  output logic        part_last,
  output logic [7:0]  rs1_byte,
  output logic [7:0]  rs2_byte,
  input  logic [7:0]  alu_result,
  output logic [63:0] result,
  output logic        result_valid,
  input  logic        result_ready
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [2:0]  r_step;
  logic [1:0]  r_order;
  logic [63:0] r_rs1;
  logic [63:0] r_rs2;
  logic [63:0] r_result;
  logic [2:0]  w_part;
  logic        w_issue_fire;

  assign w_issue_fire = issue_valid && issue_ready;

  // Byte index for the current step; reserved order 11 falls back to ascending.
  always_comb begin
    case (r_order)
      2'b01:   w_part = 3'd7 - r_step;
      2'b10:   w_part = {r_step[2], ~r_step[1:0]};
      default: w_part = r_step;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (issue_valid) w_state_next = c_ST_RUN;
      end
      c_ST_RUN: begin
        if (!stall && (r_step == 3'd7)) w_state_next = c_ST_DONE;
      end
      c_ST_DONE: begin
        if (result_ready) begin
`ifdef CLARVI_SEQ_BYPASS_EN
          w_state_next = issue_valid ? c_ST_RUN : c_ST_IDLE;
`else
          w_state_next = c_ST_IDLE;
`endif
        end
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    issue_ready  = 1'b0;
    part_valid   = 1'b0;
    instr_part   = 3'd0;
    part_first   = 1'b0;
    part_last    = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      c_ST_IDLE: issue_ready = 1'b1;
      c_ST_RUN: begin
        part_valid = 1'b1;
        instr_part = w_part;
        part_first = (r_step == 3'd0);
        part_last  = (r_step == 3'd7);
      end
      c_ST_DONE: begin
        result_valid = 1'b1;
`ifdef CLARVI_SEQ_BYPASS_EN
        issue_ready  = result_ready;
`endif
      end
      default: ;
    endcase
  end

  // Operand latch, step counter and result assembly; stall freezes all of it in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_order  <= '0;
      r_step   <= '0;
      r_result <= '0;
    end else if (w_issue_fire) begin
      r_rs1   <= issue_rs1;
      r_rs2   <= issue_rs2;
      r_order <= issue_order;
      r_step  <= '0;
      if (CLEAR_ON_ISSUE != 0) r_result <= '0;
    end else if ((r_state == c_ST_RUN) && !stall) begin
      r_result[{instr_part, 3'b000} +: 8] <= alu_result;
      r_step <= r_step + 3'd1;
    end
  end

  assign rs1_byte = r_rs1[{instr_part, 3'b000} +: 8];
  assign rs2_byte = r_rs2[{instr_part, 3'b000} +: 8];
  assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_clarvi_byte_sequencer.sv
`default_nettype none
// Directed bench for clarvi_byte_sequencer: loopback ALU (alu_result = rs1_byte)
// with an override used to inject a poison byte during stalls.
module tb_clarvi_byte_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [1:0]  issue_order = 2'b00;
  logic [63:0] issue_rs1 = '0;
  logic [63:0] issue_rs2 = '0;
  logic        part_valid;
  logic [2:0]  instr_part;
  logic        part_first;
  logic        part_last;
  logic [7:0]  rs1_byte;
  logic [7:0]  rs2_byte;
  logic [7:0]  alu_result;
  logic [63:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        alu_ovr = 1'b0;
  logic [7:0]  alu_val = 8'h00;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] A = 64'h0123456789ABCDEF;
  localparam logic [63:0] B = 64'hFEDCBA9876543210;

  assign alu_result = alu_ovr ? alu_val : rs1_byte;

  always #5 clock = ~clock;

  clarvi_byte_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_order(issue_order),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .part_valid(part_valid), .instr_part(instr_part), .part_first(part_first),
    .part_last(part_last), .rs1_byte(rs1_byte), .rs2_byte(rs2_byte),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers an operation and returns one step after the accepting edge (interval 1).
  task automatic issue_op(input logic [63:0] a, input logic [1:0] ord);
    int n = 0;
    while (issue_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait: issue_ready=%b required 1", issue_ready);
    end
    issue_valid = 1'b1;
    issue_rs1   = a;
    issue_rs2   = ~a;
    issue_order = ord;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({issue_ready, part_valid, result_valid, part_first, part_last} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: rdy/pv/rv/pf/pl=%b required 10000",
               {issue_ready, part_valid, result_valid, part_first, part_last});
    end
    checks++;
    if (result !== 64'h0 || instr_part !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: result=%h part=%0d required 0 0", result, instr_part);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_order(input string name, input logic [63:0] a, input logic [1:0] ord,
                            input logic [23:0] seq);
    logic [5:0] got;
    logic [5:0] want;
    logic [2:0] ep;
    logic [63:0] na;
    na = ~a;
    issue_op(a, ord);
    for (int k = 0; k < 8; k++) begin
      ep   = seq[3*k +: 3];
      got  = {part_valid, instr_part, part_first, part_last};
      want = {1'b1, ep, (k == 0), (k == 7)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s_part%0d: pv/part/pf/pl=%b required %b", name, k, got, want);
      end
      checks++;
      if (rs2_byte !== na[{ep, 3'b000} +: 8]) begin
        errors++;
        $display("FAIL %s_rs2_byte%0d: got %h required %h", name, k, rs2_byte, na[{ep, 3'b000} +: 8]);
      end
      tick();
    end
    checks++;
    if (result_valid !== 1'b1 || part_valid !== 1'b0 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: rv/pv/rdy=%b%b%b required 100", name, result_valid, part_valid, issue_ready);
    end
    checks++;
    if (result !== a) begin
      errors++;
      $display("FAIL %s_result: got %h required %h", name, result, a);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1 || result !== a) begin
      errors++;
      $display("FAIL %s_handshake: rv=%b rdy=%b result=%h required 0 1 %h",
               name, result_valid, issue_ready, result, a);
    end
  endtask

  // Leaves the sequencer in DONE holding A for the backpressure test.
  task automatic test_stall();
    issue_op(A, 2'b00);
    tick();
    tick();
    stall   = 1'b1;
    alu_ovr = 1'b1;
    alu_val = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr_part !== 3'd2 || part_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: part=%0d pv=%b required 2 1", k, instr_part, part_valid);
      end
    end
    stall   = 1'b0;
    alu_ovr = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (result_valid !== 1'b0 || part_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_t11: rv=%b pl=%b required 0 1", result_valid, part_last);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== A) begin
      errors++;
      $display("FAIL stall_t12: rv=%b result=%h required 1 %h", result_valid, result, A);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      issue_valid = (k == 2);
      issue_rs1   = 64'h5555AAAA5555AAAA;
      checks++;
      if (result_valid !== 1'b1 || issue_ready !== 1'b0 || result !== A) begin
        errors++;
        $display("FAIL backpressure%0d: rv=%b rdy=%b result=%h required 1 0 %h",
                 k, result_valid, issue_ready, result, A);
      end
      tick();
    end
    issue_valid  = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (part_valid !== 1'b0 || result_valid !== 1'b0 || issue_ready !== 1'b1 || result !== A) begin
      errors++;
      $display("FAIL backpressure_release: pv=%b rv=%b rdy=%b result=%h required 0 0 1 %h",
               part_valid, result_valid, issue_ready, result, A);
    end
  endtask

  task automatic test_reset_mid_op();
    issue_op(A, 2'b00);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (instr_part !== 3'd4) begin
      errors++;
      $display("FAIL midreset_step: part=%0d required 4", instr_part);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (result !== 64'h0 || part_valid !== 1'b0 || issue_ready !== 1'b1 ||
        instr_part !== 3'd0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: result=%h pv=%b rdy=%b part=%0d rv=%b required 0 0 1 0 0",
               result, part_valid, issue_ready, instr_part, result_valid);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    test_order("after_reset", B, 2'b00, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
  endtask

  task automatic test_back_to_back();
    int gap;
    issue_op(A, 2'b00);
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: rv=%b required 1", result_valid);
    end
    result_ready = 1'b1;
    issue_valid  = 1'b1;
    issue_rs1    = B;
    issue_rs2    = ~B;
    issue_order  = 2'b01;
`ifdef CLARVI_SEQ_BYPASS_EN
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: issue_ready=%b required 1", issue_ready);
    end
    tick();
    result_ready = 1'b0;
    issue_valid  = 1'b0;
    gap = 1;
`else
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: issue_ready=%b required 0", issue_ready);
    end
    tick();
    result_ready = 1'b0;
    checks++;
    if (part_valid !== 1'b0 || result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_bubble: pv=%b rv=%b rdy=%b required 0 0 1",
               part_valid, result_valid, issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    gap = 2;
`endif
    checks++;
    if (part_first !== 1'b1 || part_valid !== 1'b1 || instr_part !== 3'd7) begin
      errors++;
      $display("FAIL b2b_second_first: pf=%b pv=%b part=%0d required 1 1 7",
               part_first, part_valid, instr_part);
    end
    while (result_valid !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
`ifdef CLARVI_SEQ_BYPASS_EN
    checks++;
    if (gap !== 9) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles required 9", gap);
    end
`else
    checks++;
    if (gap !== 10) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles required 10", gap);
    end
`endif
    checks++;
    if (result !== B) begin
      errors++;
      $display("FAIL b2b_result: got %h required %h", result, B);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order("asc",   A, 2'b00, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    test_order("desc",  A, 2'b01, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
    test_order("shr32", A, 2'b10, {3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3});
    test_order("rsvd",  B, 2'b11, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    test_stall();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
